baud_gen: RTL and testbench
===========================

# baud_gen

Parametrised baud tick generator for the UART interface. It generalises the fixed oversampling rate and integer-only divider into a runtime-programmable fractional divider with a configurable oversampling rate. It produces oversample, mid-bit sample and bit ticks for the UART RX/TX datapaths. Divisor updates are shadowed and applied glitch-free at bit boundaries, and the bit phase can be re-aligned on demand, for example on an RX start-bit edge.

## Interface
- OVSAMP_RATE, 8, oversample ticks per bit; even, ≥4
- DIV_WIDTH, 16, width of integer divisor
- FRAC_WIDTH, 4, width of fractional divisor (units of 1/2^FRAC_WIDTH clock)
- DEFAULT_INT, 54, integer divisor after reset; ≥2
- DEFAULT_FRAC, 4, fractional divisor after reset
- clk_i  in  1  system clock; single clock domain
- rst_ni  in  1  reset, asynchronous assert, active-low
- en_i  in  1  generator enable
- sync_i  in  1  single-cycle pulse; restart bit phase
- div_load_i  in  1  single-cycle pulse; latch div_int_i/div_frac_i
- div_int_i  in  DIV_WIDTH  requested integer divisor
- div_frac_i  in  FRAC_WIDTH  requested fractional divisor
- ovsamp_tick_o  out  1  one-cycle pulse per oversample period
- mid_tick_o  out  1  one-cycle pulse at bit sample point
- bit_tick_o  out  1  one-cycle pulse at end of each bit
- cfg_pending_o  out  1  shadow divisor waiting to be applied
- cfg_err_o  out  1  one-cycle pulse: load rejected

## Operation
- Reset: active divisor = DEFAULT_INT/DEFAULT_FRAC. Shadow is cleared. cnt = DEFAULT_INT-1, acc = 0, ov_cnt = 0. All outputs 0.
- Down-counter cnt. Terminal count at cnt==0 with en_i=1.
- At terminal count:
  - {carry, acc} <= acc + act_frac, computed at FRAC_WIDTH+1 bits.
  - cnt <= act_int - 1 + carry.
  - ovsamp_tick_o is registered high for the next cycle.
- Average period = act_int + act_frac/2^FRAC_WIDTH clocks. The first period after a restart is exactly act_int.
- ov_cnt (width clog2(OVSAMP_RATE)) increments on each terminal count and wraps at OVSAMP_RATE-1.
  - mid_tick_o accompanies the ovsamp tick where ov_cnt was OVSAMP_RATE/2-1.
  - bit_tick_o accompanies the ovsamp tick where ov_cnt was OVSAMP_RATE-1.
- en_i=0: cnt = act_int-1, acc = 0, ov_cnt = 0, held every cycle. No ticks are emitted.
- sync_i=1: same reload as en_i=0, for one cycle. It overrides a coincident terminal count, so no tick is emitted in that cycle.
- div_load_i:
  - div_int_i < 2: rejected. cfg_err_o pulses for one cycle; shadow and pending are unchanged.
  - Otherwise: shadow <= inputs, cfg_pending_o <= 1. A later load before the apply point overwrites the shadow.
- Apply point: active <= shadow and pending <= 0. This happens on:
  - the terminal count that produces bit_tick_o, or
  - any cycle with en_i=0 or sync_i=1.
  - The cnt reload in that cycle already uses the new divisor.
- A div_load_i coinciding with an apply point is latched as pending. It is applied at the next apply point.

## Timing
- Ticks are registered. The first ovsamp_tick_o is high act_int cycles after the first clock edge with en_i=1.
- Integer-only divisor: ovsamp_tick_o period = act_int; bit_tick_o period = OVSAMP_RATE·act_int.
- mid_tick_o and bit_tick_o coincide with an ovsamp_tick_o and are never simultaneous with each other.
- cfg_pending_o rises the cycle after an accepted div_load_i. It falls the cycle after the apply point.
- Reset mid-operation clears all state immediately. Outputs drop asynchronously.
- Arithmetic: cnt is DIV_WIDTH bits, reloaded to ≤ 2^DIV_WIDTH-1. It never underflows because act_int ≥ 2.

## Test plan
- Reset values, then en_i=1 with OVSAMP_RATE=8, int=4, frac=0:
  - ovsamp ticks every 4 cycles, first one 4 cycles after enable.
  - mid_tick_o at the 4th ovsamp tick (cycle 16).
  - bit_tick_o every 32 cycles.
- Fractional divisor, int=4, frac=8, FRAC_WIDTH=4:
  - ovsamp periods 4,4,5,4,5,….
  - 16 ticks span exactly 72 cycles.
  - With frac=4, 16 ticks span 68 cycles.
- Load int=6 mid-bit (ov_cnt=3):
  - cfg_pending_o=1 until the next bit_tick_o.
  - The ovsamp period changes from 4 to 6 starting with the period after that tick.
  - Two loads before the apply point: only the last takes effect.
- Load int=1:
  - cfg_err_o pulses for one cycle.
  - cfg_pending_o stays 0 and the period is unchanged.
- Assert sync_i coincident with a terminal count:
  - no tick that cycle.
  - The next ovsamp tick follows act_int cycles later, and the next mid_tick_o follows 4·act_int cycles later.
- Drop rst_ni mid-bit with ticks active: all outputs go to 0 immediately. After release, the divisor is DEFAULT_INT/DEFAULT_FRAC and the phase restarts.

Source files
------------

// File: rtl/baud_gen.sv
// Baud tick generator with a fractional divisor and a programmable
// oversampling rate. It produces oversample, mid-bit and end-of-bit ticks.
// Divisor writes go to a shadow register. The shadow is applied at a bit
// boundary, or whenever the generator is idle or re-synchronised.
module baud_gen #(
  parameter int OVSAMP_RATE  = 8,
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4,
  parameter int DEFAULT_INT  = 54,
  parameter int DEFAULT_FRAC = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  sync_i,
  input  logic                  div_load_i,
  input  logic [DIV_WIDTH-1:0]  div_int_i,
  input  logic [FRAC_WIDTH-1:0] div_frac_i,
  output logic                  ovsamp_tick_o,
  output logic                  mid_tick_o,
  output logic                  bit_tick_o,
  output logic                  cfg_pending_o,
  output logic                  cfg_err_o
);

  localparam int OV_W = (OVSAMP_RATE > 1) ? $clog2(OVSAMP_RATE) : 1;
  localparam logic [OV_W-1:0] OV_LAST = OV_W'(OVSAMP_RATE - 1);
  localparam logic [OV_W-1:0] OV_MID  = OV_W'(OVSAMP_RATE / 2 - 1);

  logic [DIV_WIDTH-1:0]  cnt_reg;
  logic [FRAC_WIDTH-1:0] acc_reg;
  logic [OV_W-1:0]       ov_cnt_reg;
  logic [DIV_WIDTH-1:0]  act_int_reg;
  logic [FRAC_WIDTH-1:0] act_frac_reg;
  logic [DIV_WIDTH-1:0]  shd_int_reg;
  logic [FRAC_WIDTH-1:0] shd_frac_reg;
  logic                  pending_reg;
  logic                  ovsamp_tick_reg;
  logic                  mid_tick_reg;
  logic                  bit_tick_reg;
  logic                  cfg_err_reg;

  logic                  term_cnt;
  logic                  bit_end;
  logic                  apply;
  logic                  load_ok;
  logic                  restart;
  logic [DIV_WIDTH-1:0]  eff_int;
  logic [FRAC_WIDTH-1:0] eff_frac;
  logic [FRAC_WIDTH:0]   frac_sum;

  // Decode terminal count, the apply point and the divisor in force this cycle
  always_comb begin
    restart  = !en_i || sync_i;
    term_cnt = en_i && !sync_i && (cnt_reg == '0);
    bit_end  = term_cnt && (ov_cnt_reg == OV_LAST);
    apply    = restart || bit_end;
    load_ok  = div_load_i && (div_int_i >= DIV_WIDTH'(2));
    // A reload that coincides with the apply point already uses the shadow value
    eff_int  = (apply && pending_reg) ? shd_int_reg  : act_int_reg;
    eff_frac = (apply && pending_reg) ? shd_frac_reg : act_frac_reg;
    frac_sum = {1'b0, acc_reg} + {1'b0, eff_frac};
  end

  // Period counter, fractional accumulator and oversample phase
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg    <= DIV_WIDTH'(DEFAULT_INT - 1);
      acc_reg    <= '0;
      ov_cnt_reg <= '0;
    end else if (restart) begin
      cnt_reg    <= eff_int - DIV_WIDTH'(1);
      acc_reg    <= '0;
      ov_cnt_reg <= '0;
    end else if (term_cnt) begin
      // The carry out of the accumulator stretches this period by one clock
      cnt_reg    <= eff_int - DIV_WIDTH'(1) + DIV_WIDTH'(frac_sum[FRAC_WIDTH]);
      acc_reg    <= frac_sum[FRAC_WIDTH-1:0];
      ov_cnt_reg <= (ov_cnt_reg == OV_LAST) ? '0 : ov_cnt_reg + OV_W'(1);
    end else begin
      cnt_reg    <= cnt_reg - DIV_WIDTH'(1);
    end
  end

  // Active/shadow divisor registers and the pending flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_int_reg  <= DIV_WIDTH'(DEFAULT_INT);
      act_frac_reg <= FRAC_WIDTH'(DEFAULT_FRAC);
      shd_int_reg  <= '0;
      shd_frac_reg <= '0;
      pending_reg  <= 1'b0;
    end else begin
      act_int_reg  <= eff_int;
      act_frac_reg <= eff_frac;
      // A load on the apply cycle waits for the next apply point
      if (load_ok) begin
        shd_int_reg  <= div_int_i;
        shd_frac_reg <= div_frac_i;
        pending_reg  <= 1'b1;
      end else if (apply) begin
        pending_reg  <= 1'b0;
      end
    end
  end

  // Registered tick and error pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovsamp_tick_reg <= 1'b0;
      mid_tick_reg    <= 1'b0;
      bit_tick_reg    <= 1'b0;
      cfg_err_reg     <= 1'b0;
    end else begin
      ovsamp_tick_reg <= term_cnt;
      mid_tick_reg    <= term_cnt && (ov_cnt_reg == OV_MID);
      bit_tick_reg    <= bit_end;
      cfg_err_reg     <= div_load_i && !load_ok;
    end
  end

  assign ovsamp_tick_o = ovsamp_tick_reg;
  assign mid_tick_o    = mid_tick_reg;
  assign bit_tick_o    = bit_tick_reg;
  assign cfg_pending_o = pending_reg;
  assign cfg_err_o     = cfg_err_reg;

endmodule

// File: tb/tb_baud_gen.sv
// Testbench for baud_gen. A tick-level reference model runs alongside the
// DUT and sets the expected outputs for every cycle. Directed steps on top
// of that measure tick spacing against values worked out by hand.
module tb_baud_gen;

  localparam int OV    = 8;
  localparam int DW    = 16;
  localparam int FW    = 4;
  localparam int DINT  = 54;
  localparam int DFRAC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          sync = 1'b0;
  logic          load = 1'b0;
  logic [DW-1:0] di = '0;
  logic [FW-1:0] df = '0;
  logic          ovt, midt, bitt, pend, err;

  baud_gen #(
    .OVSAMP_RATE (OV),
    .DIV_WIDTH   (DW),
    .FRAC_WIDTH  (FW),
    .DEFAULT_INT (DINT),
    .DEFAULT_FRAC(DFRAC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .sync_i       (sync),
    .div_load_i   (load),
    .div_int_i    (di),
    .div_frac_i   (df),
    .ovsamp_tick_o(ovt),
    .mid_tick_o   (midt),
    .bit_tick_o   (bitt),
    .cfg_pending_o(pend),
    .cfg_err_o    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: clocks left until the next oversample tick,
  // fractional phase, tick index within the bit, divisors and pending flag
  int m_rem, m_ph, m_tib, m_ai, m_af, m_si, m_sf, m_pend;
  int e_ov, e_mid, e_bit, e_err;

  int t_ov[$];
  int t_mid[$];
  int t_bit[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_rem = DINT; m_ph = 0; m_tib = 0;
    m_ai = DINT; m_af = DFRAC; m_si = 0; m_sf = 0; m_pend = 0;
    e_ov = 0; e_mid = 0; e_bit = 0; e_err = 0;
  endtask

  // One clock edge of the model, using the inputs the DUT sampled
  task automatic model_edge;
    bit tc, last, apply;
    int ni, nf, s;
    e_err = (load && di < 2) ? 1 : 0;
    tc    = en && !sync && (m_rem == 1);
    last  = tc && (m_tib == OV - 1);
    apply = !en || sync || last;
    ni    = (apply && m_pend != 0) ? m_si : m_ai;
    nf    = (apply && m_pend != 0) ? m_sf : m_af;
    e_ov  = tc ? 1 : 0;
    e_mid = (tc && m_tib == OV / 2 - 1) ? 1 : 0;
    e_bit = last ? 1 : 0;
    if (!en || sync) begin
      m_rem = ni; m_ph = 0; m_tib = 0;
    end else if (tc) begin
      s     = m_ph + nf;
      m_rem = ni + s / (1 << FW);
      m_ph  = s % (1 << FW);
      m_tib = (m_tib + 1) % OV;
    end else begin
      m_rem--;
    end
    m_ai = ni; m_af = nf;
    if (load && di >= 2) begin
      m_si = int'(di); m_sf = int'(df); m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
  endtask

  // One clock cycle: advance the model, compare every output, log ticks
  task automatic step;
    @(posedge clk);
    model_edge;
    @(negedge clk);
    chk("ovsamp", ovt, e_ov);
    chk("mid", midt, e_mid);
    chk("bit", bitt, e_bit);
    chk("pending", pend, m_pend);
    chk("err", err, e_err);
    if (ovt)  t_ov.push_back(cyc);
    if (midt) t_mid.push_back(cyc);
    if (bitt) t_bit.push_back(cyc);
    $display("cyc=%0d en=%0b sync=%0b load=%0b di=%0d df=%0d ov=%0b mid=%0b bit=%0b pend=%0b err=%0b",
             cyc, en, sync, load, di, df, ovt, midt, bitt, pend, err);
    load = 1'b0;
    sync = 1'b0;
  endtask

  function automatic int qsize(input int kind);
    if (kind == 0) return t_ov.size();
    if (kind == 1) return t_mid.size();
    return t_bit.size();
  endfunction

  // Step until the given tick log reaches n entries, bounded by budget
  task automatic run_until(input int kind, input int n, input int budget, input string tag);
    int k = 0;
    while (qsize(kind) < n && k < budget) begin
      step;
      k++;
    end
    chk(tag, (qsize(kind) >= n) ? 1 : 0, 1);
  endtask

  task automatic clear_logs;
    t_ov.delete(); t_mid.delete(); t_bit.delete();
  endtask

  // Program a divisor while idle so it is applied on the following cycle
  task automatic program_idle(input int ival, input int fval);
    en = 1'b0; di = DW'(ival); df = FW'(fval); load = 1'b1;
    step;
    step;
  endtask

  int en_cyc, tb0, n0, s_cyc;

  initial begin
    model_reset;
    repeat (2) @(negedge clk);
    chk("rst_ovsamp", ovt, 0);
    chk("rst_mid", midt, 0);
    chk("rst_bit", bitt, 0);
    chk("rst_pending", pend, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // Integer divisor 4
    di = 4; df = 0; load = 1'b1;
    step;
    chk("pend_rise", pend, 1);
    step;
    chk("pend_fall_idle", pend, 0);
    clear_logs;
    en_cyc = cyc; en = 1'b1;
    run_until(2, 2, 100, "int_bits_seen");
    chk("first_ov", t_ov[0] - en_cyc, 4);
    chk("ov_period", t_ov[1] - t_ov[0], 4);
    chk("first_mid", t_mid[0] - en_cyc, 16);
    chk("bit_period", t_bit[1] - t_bit[0], 32);
    chk("mid_to_bit", t_bit[0] - t_mid[0], 16);

    // Fractional divisor 4 + 8/16
    program_idle(4, 8);
    clear_logs;
    en_cyc = cyc; en = 1'b1;
    run_until(0, 17, 120, "frac8_ticks_seen");
    chk("frac8_p0", t_ov[0] - en_cyc, 4);
    chk("frac8_p1", t_ov[1] - t_ov[0], 4);
    chk("frac8_p2", t_ov[2] - t_ov[1], 5);
    chk("frac8_p3", t_ov[3] - t_ov[2], 4);
    chk("frac8_span16", t_ov[16] - t_ov[0], 72);

    // Fractional divisor 4 + 4/16
    program_idle(4, 4);
    clear_logs;
    en = 1'b1;
    run_until(0, 17, 120, "frac4_ticks_seen");
    chk("frac4_span16", t_ov[16] - t_ov[0], 68);

    // Load int=6 while ov_cnt is 3
    program_idle(4, 0);
    clear_logs;
    en = 1'b1;
    run_until(0, 3, 40, "pre_load_ticks");
    di = 6; df = 0; load = 1'b1;
    step;
    chk("midbit_pend", pend, 1);
    run_until(2, 1, 60, "load6_bit_seen");
    chk("pend_after_apply", pend, 0);
    tb0 = t_bit[0];
    n0 = t_ov.size();
    run_until(0, n0 + 1, 20, "load6_next_tick");
    chk("period_after_load6", t_ov[t_ov.size() - 1] - tb0, 6);

    // Two loads before the apply point: the later one wins
    di = 5; load = 1'b1;
    step;
    di = 7; load = 1'b1;
    step;
    n0 = t_bit.size();
    run_until(2, n0 + 1, 80, "dbl_bit_seen");
    tb0 = t_bit[t_bit.size() - 1];
    n0 = t_ov.size();
    run_until(0, n0 + 1, 20, "dbl_next_tick");
    chk("period_after_dbl", t_ov[t_ov.size() - 1] - tb0, 7);

    // Rejected load of int=1
    di = 1; df = 3; load = 1'b1;
    step;
    chk("err_pulse", err, 1);
    chk("err_no_pend", pend, 0);
    step;
    chk("err_one_cycle", err, 0);
    n0 = t_ov.size();
    run_until(0, n0 + 2, 30, "err_ticks_seen");
    chk("err_period_kept", t_ov[n0 + 1] - t_ov[n0], 7);

    // sync_i on a terminal count
    begin
      int k = 0;
      while (m_rem != 1 && k < 20) begin step; k++; end
    end
    chk("sync_tc_found", (m_rem == 1) ? 1 : 0, 1);
    clear_logs;
    sync = 1'b1;
    step;
    s_cyc = cyc;
    chk("sync_no_tick", ovt, 0);
    run_until(0, 1, 20, "sync_ov_seen");
    chk("sync_ov_delay", t_ov[0] - s_cyc, 7);
    run_until(1, 1, 60, "sync_mid_seen");
    chk("sync_mid_delay", t_mid[0] - s_cyc, 28);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      en   = ($urandom_range(0, 19) != 0);
      sync = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 15) == 0);
      di   = DW'($urandom_range(0, 9));
      df   = FW'($urandom);
      step;
    end

    // Reset mid-bit with a tick and a pending load active
    program_idle(4, 0);
    en = 1'b1;
    di = 6; load = 1'b1;
    step;
    clear_logs;
    run_until(0, 2, 20, "pre_reset_ticks");
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ovsamp", ovt, 0);
    chk("arst_mid", midt, 0);
    chk("arst_bit", bitt, 0);
    chk("arst_pending", pend, 0);
    chk("arst_err", err, 0);
    model_reset;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs;
    en_cyc = cyc;
    run_until(0, 2, 200, "post_reset_ticks");
    chk("post_reset_first", t_ov[0] - en_cyc, DINT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
